// File: rtl/combo_lock_pkg.sv
// Shared types and constants for the parameterised combination lock:
// state encodings, seven-segment digit images and a BCD range helper.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        ENTRY_OK  = 3'd0,
        ENTRY_BAD = 3'd1,
        OPEN      = 3'd2,
        ERROR     = 3'd3,
        PROG      = 3'd4,
        LOCKOUT   = 3'd5
    } lock_state_e;

    // Active-low segment images, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b100_0000;
    localparam logic [6:0] SEG_1     = 7'b111_1001;
    localparam logic [6:0] SEG_2     = 7'b010_0100;
    localparam logic [6:0] SEG_3     = 7'b011_0000;
    localparam logic [6:0] SEG_4     = 7'b001_1001;
    localparam logic [6:0] SEG_5     = 7'b001_0010;
    localparam logic [6:0] SEG_6     = 7'b000_0010;
    localparam logic [6:0] SEG_7     = 7'b111_1000;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b001_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    localparam logic [3:0] HINT_NONE = 4'hF;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/combo_lock_seg7.sv
// Active-low seven-segment decoder: digits 0-9 are drawn, anything above 9
// leaves the display blank.
module combo_lock_seg7
    import combo_lock_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/combo_lock_param.sv
// Parameterised digit-entry combination lock with programmable code.
// Define COMBO_LOCK_LOCKOUT_EN to build in the failed-attempt lockout.
module combo_lock_param
    import combo_lock_pkg::*;
#(
    parameter int                    CODE_LEN       = 6,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 24'h305464,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       close_req,
    input  logic       prog_req,
    output logic [2:0] state,
    output logic       is_open,
    output logic       is_error,
    output logic       is_locked,
    output logic [3:0] hint_digit,
    output logic [6:0] hex0
);

    localparam int                IDX_W    = $clog2(CODE_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CODE_LEN - 1);

    if (CODE_LEN < 2 || CODE_LEN > 8 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("combo_lock_param: illegal parameter set");
    end

    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       code_q [CODE_LEN];
    logic             code_we;
    logic [3:0]       cur_digit;
    logic             is_last;

`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam int               FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);
    localparam int               TMR_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

    logic [FAIL_W-1:0] fail_q, fail_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
`endif

    assign cur_digit = code_q[idx_q];
    assign is_last   = (idx_q == LAST_IDX);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_we = 1'b0;
        case (state_q)
            ENTRY_OK: if (digit_valid) begin
                if (is_bcd(digit_in) && digit_in == cur_digit) begin
                    state_d = is_last ? OPEN : ENTRY_OK;
                    idx_d   = is_last ? '0 : idx_q + 1'b1;
                end else begin
                    state_d = is_last ? ERROR : ENTRY_BAD;
                    idx_d   = is_last ? '0 : idx_q + 1'b1;
                end
            end
            ENTRY_BAD: if (digit_valid) begin
                state_d = is_last ? ERROR : ENTRY_BAD;
                idx_d   = is_last ? '0 : idx_q + 1'b1;
            end
            OPEN: begin
                if (close_req) begin
                    state_d = ENTRY_OK;
                end else if (prog_req) begin
                    state_d = PROG;
                    idx_d   = '0;
                end
            end
            PROG: if (digit_valid && is_bcd(digit_in)) begin
                code_we = 1'b1;
                state_d = is_last ? ENTRY_OK : PROG;
                idx_d   = is_last ? '0 : idx_q + 1'b1;
            end
            ERROR: if (close_req) begin
`ifdef COMBO_LOCK_LOCKOUT_EN
                state_d = (fail_q == FAIL_MAX) ? LOCKOUT : ENTRY_OK;
`else
                state_d = ENTRY_OK;
`endif
                idx_d   = '0;
            end
            LOCKOUT: begin
`ifdef COMBO_LOCK_LOCKOUT_EN
                if (timer_q == '0) state_d = ENTRY_OK;
`else
                state_d = ENTRY_OK;
`endif
            end
            default: begin
                state_d = ENTRY_OK;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ENTRY_OK;
            idx_q   <= '0;
            // NOTE: the code store is deliberately reset; a half-programmed code must not survive reset.
            for (int i = 0; i < CODE_LEN; i++) begin
                code_q[i] <= DEFAULT_CODE[4*(CODE_LEN-1-i) +: 4];
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (code_we) code_q[idx_q] <= digit_in;
        end
    end

`ifdef COMBO_LOCK_LOCKOUT_EN
    // Failure count and lockout timer follow the state transitions chosen above.
    always_comb begin
        fail_d  = fail_q;
        timer_d = timer_q;
        if (state_d == ERROR && state_q != ERROR) begin
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
        end else if ((state_d == OPEN && state_q != OPEN) ||
                     (state_q == LOCKOUT && state_d == ENTRY_OK)) begin
            fail_d = '0;
        end
        if (state_q == ERROR && state_d == LOCKOUT) begin
            timer_d = TMR_LOAD;
        end else if (state_q == LOCKOUT && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign is_locked = (state_q == LOCKOUT);
`else
    assign is_locked = 1'b0;
`endif

    assign state      = state_q;
    assign is_open    = (state_q == OPEN);
    assign is_error   = (state_q == ERROR);
    assign hint_digit = (state_q == ENTRY_OK) ? cur_digit : HINT_NONE;

    combo_lock_seg7 u_seg7 (
        .digit (hint_digit),
        .seg   (hex0)
    );

endmodule

// File: tb/tb_combo_lock_param.sv
// Self-checking bench for combo_lock_param: directed scenarios followed by
// randomized traffic, all scored against a sequence-level reference model.
module tb_combo_lock_param;

    localparam int                CODE_LEN       = 6;
    localparam logic [23:0]       DEFAULT_CODE   = 24'h305464;
    localparam int                MAX_FAIL       = 3;
    localparam int                LOCKOUT_CYCLES = 16;
`ifdef COMBO_LOCK_LOCKOUT_EN
    localparam bit                LOCK_EN        = 1'b1;
`else
    localparam bit                LOCK_EN        = 1'b0;
`endif

    // Model modes; the entry phase is one mode whose good/bad split is derived from the digits typed.
    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 2;
    localparam int M_ERROR = 3;
    localparam int M_PROG  = 4;
    localparam int M_LOCK  = 5;

    logic       clk;
    logic       reset_n;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       close_req;
    logic       prog_req;
    logic [2:0] state;
    logic       is_open;
    logic       is_error;
    logic       is_locked;
    logic [3:0] hint_digit;
    logic [6:0] hex0;

    int checks = 0;
    int errors = 0;

    int m_code [CODE_LEN];
    int m_buf  [$];
    int m_prog [$];
    int m_mode;
    int m_fails;
    int m_lock_left;

    combo_lock_param #(
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .close_req   (close_req),
        .prog_req    (prog_req),
        .state       (state),
        .is_open     (is_open),
        .is_error    (is_error),
        .is_locked   (is_locked),
        .hint_digit  (hint_digit),
        .hex0        (hex0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit prefix_ok();
        for (int i = 0; i < m_buf.size(); i++) begin
            if (m_buf[i] != m_code[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_state();
        if (m_mode == M_ENTRY) return prefix_ok() ? 0 : 1;
        return m_mode;
    endfunction

    function automatic int exp_hint();
        if (m_mode == M_ENTRY && prefix_ok()) return m_code[m_buf.size()];
        return 15;
    endfunction

    function automatic void model_reset();
        logic [23:0] v;
        v = DEFAULT_CODE;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = int'(v[4*(CODE_LEN-1-i) +: 4]);
        m_buf.delete();
        m_prog.delete();
        m_mode      = M_ENTRY;
        m_fails     = 0;
        m_lock_left = 0;
    endfunction

    // Whole-sequence model: a full code is judged only once all digits are in.
    function automatic void model_edge(input bit dv, input int d, input bit cl, input bit pr);
        case (m_mode)
            M_ENTRY: if (dv) begin
                m_buf.push_back(d);
                if (m_buf.size() == CODE_LEN) begin
                    if (prefix_ok()) begin
                        m_mode  = M_OPEN;
                        m_fails = 0;
                    end else begin
                        m_mode = M_ERROR;
                        if (m_fails < MAX_FAIL) m_fails++;
                    end
                    m_buf.delete();
                end
            end
            M_OPEN: begin
                if (cl) m_mode = M_ENTRY;
                else if (pr) begin
                    m_mode = M_PROG;
                    m_prog.delete();
                end
            end
            M_PROG: if (dv && d <= 9) begin
                m_prog.push_back(d);
                if (m_prog.size() == CODE_LEN) begin
                    for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog[i];
                    m_prog.delete();
                    m_mode = M_ENTRY;
                end
            end
            M_ERROR: if (cl) begin
                if (LOCK_EN && m_fails == MAX_FAIL) begin
                    m_mode      = M_LOCK;
                    m_lock_left = LOCKOUT_CYCLES;
                end else begin
                    m_mode = M_ENTRY;
                end
            end
            default: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_mode  = M_ENTRY;
                    m_fails = 0;
                end
            end
        endcase
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".state"},     32'(state),      32'(exp_state()));
        check({tag, ".is_open"},   32'(is_open),    32'(m_mode == M_OPEN));
        check({tag, ".is_error"},  32'(is_error),   32'(m_mode == M_ERROR));
        check({tag, ".is_locked"}, 32'(is_locked),  32'(m_mode == M_LOCK));
        check({tag, ".hint"},      32'(hint_digit), 32'(exp_hint()));
        check({tag, ".hex0"},      32'(hex0),       32'(seg_ref(exp_hint())));
    endtask

    task automatic step(input string tag, input logic dv, input logic [3:0] d,
                        input logic cl, input logic pr);
        digit_valid = dv;
        digit_in    = d;
        close_req   = cl;
        prog_req    = pr;
        @(posedge clk);
        model_edge(dv, int'(d), cl, pr);
        #1;
        digit_valid = 1'b0;
        close_req   = 1'b0;
        prog_req    = 1'b0;
        compare_all(tag);
    endtask

    task automatic enter(input string tag, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, v[4*i +: 4], 1'b0, 1'b0);
    endtask

    task automatic do_async_reset(input string tag);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".hint_rst"}, 32'(hint_digit), 32'd3);
        check({tag, ".hex3"},  32'(hex0),       32'h30);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic       r_dv, r_cl, r_pr;
        logic [3:0] r_d;

        reset_n     = 1'b0;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        close_req   = 1'b0;
        prog_req    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compare_all("reset");
        check("reset.state_const", 32'(state),      32'd0);
        check("reset.hint_const",  32'(hint_digit), 32'd3);
        check("reset.hex_const",   32'(hex0),       32'b0110000);

        enter("good_code", 32'h305464, 6);
        check("good_code.open", 32'(is_open), 32'd1);
        step("close", 1'b0, 4'd0, 1'b1, 1'b0);

        enter("bad_head", 32'h300, 3);
        check("bad_head.state", 32'(state),      32'd1);
        check("bad_head.hint",  32'(hint_digit), 32'hF);
        enter("bad_tail", 32'h464, 3);
        check("bad_tail.error", 32'(is_error), 32'd1);
        step("ack", 1'b0, 4'd0, 1'b1, 1'b0);

        enter("reopen", 32'h305464, 6);
        step("prog_req", 1'b0, 4'd0, 1'b0, 1'b1);
        enter("prog_digits", 32'h12C3456, 7);
        check("prog_done.state", 32'(state), 32'd0);
        enter("old_code", 32'h305464, 6);
        check("old_code.error", 32'(is_error), 32'd1);
        step("ack2", 1'b0, 4'd0, 1'b1, 1'b0);
        enter("new_code", 32'h123456, 6);
        check("new_code.open", 32'(is_open), 32'd1);

        step("close_and_prog", 1'b0, 4'd0, 1'b1, 1'b1);
        check("close_wins.state", 32'(state), 32'd0);

        enter("new_code2", 32'h123456, 6);
        step("prog_req2", 1'b0, 4'd0, 1'b0, 1'b1);
        enter("prog_partial", 32'h99, 2);
        do_async_reset("reset_in_prog");
        enter("default_back", 32'h305464, 6);
        check("default_back.open", 32'(is_open), 32'd1);
        step("close3", 1'b0, 4'd0, 1'b1, 1'b0);

        enter("fail1", 32'h111111, 6);
        step("fail1_ack", 1'b0, 4'd0, 1'b1, 1'b0);
        enter("fail2_nonbcd", 32'h2A2222, 6);
        step("fail2_ack", 1'b0, 4'd0, 1'b1, 1'b0);
        enter("fail3", 32'h333333, 6);
        step("fail3_ack", 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef COMBO_LOCK_LOCKOUT_EN
        check("lock.entered", 32'(is_locked), 32'd1);
        for (int i = 0; i < LOCKOUT_CYCLES - 1; i++) begin
            step("lock_hold", 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        end
        check("lock.still", 32'(is_locked), 32'd1);
        step("lock_exit", 1'b1, 4'd3, 1'b0, 1'b0);
        check("lock_exit.state", 32'(state),      32'd0);
        check("lock_exit.hint",  32'(hint_digit), 32'd3);
`else
        check("nolock.locked", 32'(is_locked), 32'd0);
        check("nolock.state",  32'(state),     32'd0);
`endif

        for (int n = 0; n < 800; n++) begin
            r_dv = ($urandom_range(0, 99) < 55);
            r_cl = ($urandom_range(0, 99) < 15);
            r_pr = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 3) != 0) begin
                r_d = (m_mode == M_ENTRY && prefix_ok()) ? 4'(m_code[m_buf.size()])
                                                         : 4'($urandom_range(0, 9));
            end else begin
                r_d = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 199) == 0) do_async_reset("rand_reset");
            else step("random", r_dv, r_d, r_cl, r_pr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
